// File: rtl/cordic_iterative.sv
// Folded CORDIC engine: one micro-rotation datapath reused N_ITR times per sample,
// run-time rotation/vectoring select, tag pass-through, saturated x/y outputs.
module cordic_iterative #(
  parameter int W_NIO = 16,
  parameter int W_CAL = 32,
  parameter int N_ITR = 16,
  parameter int W_TAG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic                    in_mode,
  input  logic signed [W_NIO-1:0] in_x,
  input  logic signed [W_NIO-1:0] in_y,
  input  logic signed [W_NIO-1:0] in_z,
  input  logic        [W_TAG-1:0] in_tag,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic signed [W_NIO-1:0] out_x,
  output logic signed [W_NIO-1:0] out_y,
  output logic signed [W_NIO-1:0] out_z,
  output logic        [W_TAG-1:0] out_tag
);

  localparam int WI = W_CAL + 2;
  localparam int CW = (N_ITR > 1) ? $clog2(N_ITR) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SCALE = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Angle table entry: atan(2^-i)/pi with 1.0 at bit W_CAL-1, evaluated at elaboration.
  function automatic logic signed [WI-1:0] atan_ent(input int i);
    real                     p;
    real                     r;
    longint                  v;
    logic signed [WI+63:0]   w;
    int                      sh;
    p = 1.0;
    for (int k = 0; k < i; k++) p = p / 2.0;
    r = $atan(p) / 3.14159265358979323846;
    v = longint'(r * 4611686018427387904.0);
    w = (WI+64)'(v);
    if (W_CAL >= 63) begin
      sh = W_CAL - 63;
      w  = w <<< sh;
    end else begin
      sh = 63 - W_CAL;
      w  = (w + ((WI+64)'(1) <<< (sh - 1))) >>> sh;
    end
    return w[WI-1:0];
  endfunction

  function automatic logic signed [WI-1:0] widen(input logic signed [W_NIO-1:0] v);
    return {{2{v[W_NIO-1]}}, v, {(W_CAL-W_NIO){1'b0}}};
  endfunction

  // Shift-add CORDIC gain compensation, K ~= 0.607253.
  function automatic logic signed [WI-1:0] scale_k(input logic signed [WI-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 12)
         + (v >>> 14) + (v >>> 16) - (v >>> 20);
  endfunction

  // Floor-truncate to W_NIO bits, clamping anything the guard bits say is out of range.
  function automatic logic signed [W_NIO-1:0] sat_trunc(input logic signed [WI-1:0] v);
    logic signed [W_NIO+1:0] t;
    t = v[WI-1 -: W_NIO+2];
    if (t[W_NIO+1:W_NIO-1] == 3'b000 || t[W_NIO+1:W_NIO-1] == 3'b111)
      return t[W_NIO-1:0];
    else if (t[W_NIO+1])
      return {1'b1, {(W_NIO-1){1'b0}}};
    else
      return {1'b0, {(W_NIO-1){1'b1}}};
  endfunction

  logic [2:0]              state;
  logic [CW-1:0]           cnt;
  logic                    mode_p0;
  logic signed [W_NIO-1:0] x_p0, y_p0, z_p0;
  logic [W_TAG-1:0]        tag_p0;
  logic                    inv_p1, pi_add_p1;
  logic signed [WI-1:0]    x_p1, y_p1, z_p1;
  logic signed [WI-1:0]    e_tab [N_ITR];

  for (genvar g = 0; g < N_ITR; g++) begin : g_etab
    assign e_tab[g] = atan_ent(g);
  end

  logic                    z_flip;
  logic signed [W_NIO-1:0] z_fix;
  logic signed [WI-1:0]    x_sh, y_sh, x_fin, y_fin;
  logic                    dir;
  logic                    accept;

  assign in_rdy  = (state == S_IDLE) || (state == S_DONE && out_rdy);
  assign out_vld = (state == S_DONE);
  assign accept  = in_vld && in_rdy;

  always_comb begin
    z_flip = z_p0[W_NIO-1] ^ z_p0[W_NIO-2];
    z_fix  = z_flip ? {z_p0[W_NIO-2], z_p0[W_NIO-2:0]} : z_p0;
    x_sh   = x_p1 >>> cnt;
    y_sh   = y_p1 >>> cnt;
    dir    = mode_p0 ? y_p1[WI-1] : ~z_p1[WI-1];
    x_fin  = inv_p1 ? -x_p1 : x_p1;
    y_fin  = inv_p1 ? -y_p1 : y_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mode_p0   <= 1'b0;
      x_p0      <= '0;
      y_p0      <= '0;
      z_p0      <= '0;
      tag_p0    <= '0;
      inv_p1    <= 1'b0;
      pi_add_p1 <= 1'b0;
      x_p1      <= '0;
      y_p1      <= '0;
      z_p1      <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        // Accept: capture raw inputs; DONE with a fresh accept reloads without a bubble.
        S_IDLE, S_DONE: begin
          if (accept) begin
            state   <= S_LOAD;
            mode_p0 <= in_mode;
            x_p0    <= in_x;
            y_p0    <= in_y;
            z_p0    <= in_z;
            tag_p0  <= in_tag;
          end else if (state == S_DONE && out_rdy) begin
            state <= S_IDLE;
          end
        end
        // LOAD: fold the input into the convergence range of the micro-rotations.
        S_LOAD: begin
          state <= S_SCALE;
          if (mode_p0) begin
            inv_p1    <= 1'b0;
            pi_add_p1 <= x_p0[W_NIO-1];
            x_p1      <= x_p0[W_NIO-1] ? -widen(x_p0) : widen(x_p0);
            y_p1      <= x_p0[W_NIO-1] ? -widen(y_p0) : widen(y_p0);
            z_p1      <= '0;
          end else begin
            inv_p1    <= z_flip;
            pi_add_p1 <= 1'b0;
            x_p1      <= widen(x_p0);
            y_p1      <= widen(y_p0);
            z_p1      <= widen(z_fix);
          end
        end
        // SCALE: pre-compensate the CORDIC gain.
        S_SCALE: begin
          state <= S_ITER;
          cnt   <= '0;
          x_p1  <= scale_k(x_p1);
          y_p1  <= scale_k(y_p1);
        end
        // ITER: one micro-rotation per cycle, both updates from the previous x/y.
        S_ITER: begin
          if (dir) begin
            x_p1 <= x_p1 - y_sh;
            y_p1 <= y_p1 + x_sh;
            z_p1 <= z_p1 - e_tab[cnt];
          end else begin
            x_p1 <= x_p1 + y_sh;
            y_p1 <= y_p1 - x_sh;
            z_p1 <= z_p1 + e_tab[cnt];
          end
          if (cnt == CW'(N_ITR - 1)) begin
            cnt   <= '0;
            state <= S_FINAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // FINAL: undo the range folding and register the results.
        S_FINAL: begin
          state   <= S_DONE;
          out_x   <= sat_trunc(x_fin);
          out_y   <= sat_trunc(y_fin);
          out_z   <= {z_p1[W_CAL-1] ^ pi_add_p1, z_p1[W_CAL-2 -: W_NIO-1]};
          out_tag <= tag_p0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iterative.sv
// Directed bench for cordic_iterative: vector table plus backpressure and mid-run reset sequences.
module tb_cordic_iterative;

  localparam int LAT = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld, in_rdy, in_mode;
  logic [15:0] in_x, in_y, in_z;
  logic [3:0]  in_tag;
  logic        out_vld, out_rdy;
  logic [15:0] out_x, out_y, out_z;
  logic [3:0]  out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        mode;
    logic [15:0] x, y, z;
    logic [3:0]  tag;
    logic [15:0] ex, ey, ez;
    int          tx, ty, tz;
  } vec_t;

  vec_t vecs [12];

  cordic_iterative dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_mode (in_mode),
    .in_x    (in_x),
    .in_y    (in_y),
    .in_z    (in_z),
    .in_tag  (in_tag),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_x   (out_x),
    .out_y   (out_y),
    .out_z   (out_z),
    .out_tag (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp, input int tol);
    logic signed [15:0] d;
    d = act - exp;
    n_tests++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic send(input logic m, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic [3:0] t);
    int n;
    n = 0;
    @(negedge clk);
    in_vld = 1'b1; in_mode = m; in_x = x; in_y = y; in_z = z; in_tag = t;
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_rdy stayed %b, want 1", in_rdy);
    end
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    in_mode = 1'($urandom);
    in_x    = 16'($urandom);
    in_y    = 16'($urandom);
    in_z    = 16'($urandom);
    in_tag  = 4'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_vld && lat < 100);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{1'b0, 16'h4000, 16'h0000, 16'h2000, 4'h1, 16'h2D41, 16'h2D41, 16'h0000, 2, 2, 2};
    vecs[1]  = '{1'b0, 16'h4000, 16'h0000, 16'h8000, 4'h2, 16'hC000, 16'h0000, 16'h0000, 2, 2, 2};
    vecs[2]  = '{1'b1, 16'h0000, 16'h4000, 16'h1234, 4'h3, 16'h4000, 16'h0000, 16'h4000, 2, 2, 2};
    vecs[3]  = '{1'b1, 16'hC000, 16'h0000, 16'h5555, 4'h4, 16'h4000, 16'h0000, 16'h8000, 2, 2, 2};
    vecs[4]  = '{1'b1, 16'h7FFF, 16'h7FFF, 16'h0000, 4'h5, 16'h7FFF, 16'h0000, 16'h2000, 0, 2, 2};
    vecs[5]  = '{1'b0, 16'h4000, 16'h0000, 16'h0000, 4'h6, 16'h4000, 16'h0000, 16'h0000, 2, 2, 2};
    vecs[6]  = '{1'b0, 16'h4000, 16'h0000, 16'h4000, 4'h7, 16'h0000, 16'h4000, 16'h0000, 2, 2, 2};
    vecs[7]  = '{1'b0, 16'h4000, 16'h0000, 16'hC000, 4'h8, 16'h0000, 16'hC000, 16'h0000, 2, 2, 2};
    vecs[8]  = '{1'b0, 16'h4000, 16'h0000, 16'h6000, 4'h9, 16'hD2BF, 16'h2D41, 16'h0000, 2, 2, 2};
    vecs[9]  = '{1'b1, 16'h3000, 16'hC000, 16'h0000, 4'hA, 16'h5000, 16'h0000, 16'hDA38, 2, 2, 2};
    vecs[10] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h2000, 4'hB, 16'h0000, 16'h7FFF, 16'h0000, 2, 0, 2};
    vecs[11] = '{1'b0, 16'h8000, 16'h8000, 16'h2000, 4'hC, 16'h0000, 16'h8000, 16'h0000, 2, 0, 2};

    rst = 1'b1; in_vld = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", 16'(in_rdy), 16'h1, 0);
    chk("rst_out_vld", 16'(out_vld), 16'h0, 0);
    chk("rst_out_x", out_x, 16'h0, 0);
    chk("rst_out_y", out_y, 16'h0, 0);
    chk("rst_out_z", out_z, 16'h0, 0);
    chk("rst_out_tag", 16'(out_tag), 16'h0, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].tag);
      wait_out(lat);
      chk($sformatf("v%0d_latency", i), 16'(lat), 16'(LAT), 0);
      chk($sformatf("v%0d_x", i), out_x, vecs[i].ex, vecs[i].tx);
      chk($sformatf("v%0d_y", i), out_y, vecs[i].ey, vecs[i].ty);
      chk($sformatf("v%0d_z", i), out_z, vecs[i].ez, vecs[i].tz);
      chk($sformatf("v%0d_tag", i), 16'(out_tag), 16'(vecs[i].tag), 0);
      release_out();
    end

    // Backpressure in DONE, then a reload on the same cycle as the handshake.
    send(1'b0, 16'h4000, 16'h0000, 16'h2000, 4'h5);
    wait_out(lat);
    @(negedge clk);
    in_vld = 1'b1; in_mode = 1'b1; in_x = 16'h0000; in_y = 16'h4000; in_z = 16'h0000; in_tag = 4'h9;
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_rdy", 16'(in_rdy), 16'h0, 0);
      chk("bp_out_vld", 16'(out_vld), 16'h1, 0);
      chk("bp_out_x", out_x, 16'h2D41, 2);
      chk("bp_out_y", out_y, 16'h2D41, 2);
      chk("bp_out_tag", 16'(out_tag), 16'h5, 0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_in_rdy_rise", 16'(in_rdy), 16'h1, 0);
    @(posedge clk);
    #1;
    in_vld = 1'b0; out_rdy = 1'b0;
    chk("bp_vld_after_accept", 16'(out_vld), 16'h0, 0);
    wait_out(lat);
    chk("bp_latency", 16'(lat), 16'(LAT), 0);
    chk("bp_x", out_x, 16'h4000, 2);
    chk("bp_z", out_z, 16'h4000, 2);
    chk("bp_tag", 16'(out_tag), 16'h9, 0);
    release_out();
    @(negedge clk);
    chk("idle_out_vld", 16'(out_vld), 16'h0, 0);
    chk("idle_in_rdy", 16'(in_rdy), 16'h1, 0);
    chk("idle_hold_tag", 16'(out_tag), 16'h9, 0);
    chk("idle_hold_x", out_x, 16'h4000, 2);

    // Reset while iterating: sample dropped, outputs cleared, engine usable afterwards.
    send(1'b0, 16'h4000, 16'h0000, 16'h2000, 4'h6);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_vld", 16'(out_vld), 16'h0, 0);
    chk("mid_rst_in_rdy", 16'(in_rdy), 16'h1, 0);
    chk("mid_rst_out_x", out_x, 16'h0, 0);
    chk("mid_rst_out_z", out_z, 16'h0, 0);
    chk("mid_rst_out_tag", 16'(out_tag), 16'h0, 0);
    @(negedge clk);
    chk("mid_rst_next_vld", 16'(out_vld), 16'h0, 0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_vld) seen++;
    end
    chk("mid_rst_no_output", 16'(seen), 16'h0, 0);
    send(1'b1, 16'h0000, 16'h4000, 16'h0000, 4'hD);
    wait_out(lat);
    chk("post_rst_latency", 16'(lat), 16'(LAT), 0);
    chk("post_rst_x", out_x, 16'h4000, 2);
    chk("post_rst_z", out_z, 16'h4000, 2);
    chk("post_rst_tag", 16'(out_tag), 16'hD, 0);
    release_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
